// File: rtl/lpddr2_mem_bridge.sv
// lpddr2_mem_bridge
// Single-outstanding-transaction bridge from the CPU memory stage to the
// LPDDR2 controller user port. It latches one word read or write, runs the
// controller handshake, returns read data with a one-cycle cpu_done pulse,
// and aborts to an error completion if the controller stalls too long.
//
// Optional build macro: LPDDR2_LAST_READ_CACHE_EN
//   Adds a one-entry last-read cache. A read hit completes without touching
//   the LPDDR2 port.
//
// Ports:
//   clk, rst            bridge clock; asynchronous active-high reset
//   cpu_addr[29:0]      CPU word address (byte address [31:2])
//   cpu_wdata[31:0]     CPU write data
//   cpu_rreq, cpu_wreq  CPU read/write request, sampled in IDLE only
//   cpu_rdata[31:0]     registered read data, held until the next read completes
//   cpu_done            one-cycle completion pulse
//   busy                high in every state except IDLE
//   err                 sticky timeout/range error, cleared only by rst
//   lpddr2_address      controller word address
//   lpddr2_write_data   controller write data
//   lpddr2_read_data    controller read data
//   lpddr2_rreq/wreq    controller read/write request (registered, exclusive)
//   lpddr2_waitrequest  controller stall; request accepted when low
//   lpddr2_rdata_valid  controller read data strobe
module lpddr2_mem_bridge #(
  parameter int unsigned ADDR_W      = 27,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [29:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_rreq,
  input  logic              cpu_wreq,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_done,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W-1:0] lpddr2_address,
  output logic [31:0]       lpddr2_write_data,
  input  logic [31:0]       lpddr2_read_data,
  output logic              lpddr2_rreq,
  output logic              lpddr2_wreq,
  input  logic              lpddr2_waitrequest,
  input  logic              lpddr2_rdata_valid
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_DONE,
    S_ERR
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [CNT_W-1:0]    r_cnt;
  logic [31:0]         r_rdata;
  logic                r_done;
  logic                r_busy;
  logic                r_err;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_rreq;
  logic                r_wreq;
  logic                r_is_rd;

  logic                w_range_err;
  logic                w_timeout;
  logic                w_cache_hit;
  logic                w_capture;
  logic                w_err_is_rd;

  // Any address bit above the controller's word-address width is out of range
  assign w_range_err = (cpu_addr >> ADDR_W) != '0;
  assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Read data is taken whenever a read-side state completes normally
  assign w_capture   = ((r_state == S_RD_REQ) || (r_state == S_RD_WAIT)) &&
                       (w_next == S_DONE);

  // A range error is detected in IDLE before the op type is latched
  assign w_err_is_rd = (r_state == S_IDLE) ? !cpu_wreq : r_is_rd;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; completion and acceptance take priority over timeout
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (cpu_wreq) begin
          w_next = w_range_err ? S_ERR : S_WR_REQ;
        end else if (cpu_rreq) begin
          if (w_range_err) begin
            w_next = S_ERR;
          end else if (w_cache_hit) begin
            w_next = S_DONE;
          end else begin
            w_next = S_RD_REQ;
          end
        end
      end
      S_RD_REQ: begin
        if (!lpddr2_waitrequest) begin
          w_next = lpddr2_rdata_valid ? S_DONE : S_RD_WAIT;
        end else if (w_timeout) begin
          w_next = S_ERR;
        end
      end
      S_RD_WAIT: begin
        if (lpddr2_rdata_valid) begin
          w_next = S_DONE;
        end else if (w_timeout) begin
          w_next = S_ERR;
        end
      end
      S_WR_REQ: begin
        if (!lpddr2_waitrequest) begin
          w_next = S_DONE;
        end else if (w_timeout) begin
          w_next = S_ERR;
        end
      end
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rreq  <= 1'b0;
      r_wreq  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_is_rd <= 1'b0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      r_rreq <= (w_next == S_RD_REQ);
      r_wreq <= (w_next == S_WR_REQ);
      r_busy <= (w_next != S_IDLE);
      r_done <= (w_next == S_DONE) || (w_next == S_ERR);

      if (w_next == S_ERR) begin
        r_err <= 1'b1;
      end

      if ((r_state == S_IDLE) && (cpu_wreq || cpu_rreq)) begin
        r_addr  <= cpu_addr[ADDR_W-1:0];
        r_is_rd <= !cpu_wreq;
        if (cpu_wreq) begin
          r_wdata <= cpu_wdata;
        end
      end

      // Counter is zero in IDLE, so every request state starts from zero
      if ((r_state == S_RD_REQ) || (r_state == S_RD_WAIT) || (r_state == S_WR_REQ)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end

      if (w_capture) begin
        r_rdata <= lpddr2_read_data;
      end else if ((w_next == S_ERR) && w_err_is_rd) begin
        r_rdata <= ERR_RDATA;
      end else if ((r_state == S_IDLE) && (w_next == S_DONE)) begin
        r_rdata <= w_cache_data_sel();
      end
    end
  end

`ifdef LPDDR2_LAST_READ_CACHE_EN
  logic              r_cache_vld;
  logic [ADDR_W-1:0] r_cache_tag;
  logic [31:0]       r_cache_data;

  assign w_cache_hit = r_cache_vld && (r_cache_tag == cpu_addr[ADDR_W-1:0]);

  function automatic logic [31:0] w_cache_data_sel();
    return r_cache_data;
  endfunction

  // Last-read cache: fill on read completion, track same-address writes,
  // drop on any error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cache_vld  <= 1'b0;
      r_cache_tag  <= '0;
      r_cache_data <= '0;
    end else if (w_next == S_ERR) begin
      r_cache_vld <= 1'b0;
    end else if (w_capture) begin
      r_cache_vld  <= 1'b1;
      r_cache_tag  <= r_addr;
      r_cache_data <= lpddr2_read_data;
    end else if ((r_state == S_IDLE) && (w_next == S_WR_REQ) &&
                 (r_cache_tag == cpu_addr[ADDR_W-1:0])) begin
      r_cache_data <= cpu_wdata;
    end
  end
`else
  assign w_cache_hit = 1'b0;

  function automatic logic [31:0] w_cache_data_sel();
    return r_rdata;
  endfunction
`endif

  assign cpu_rdata         = r_rdata;
  assign cpu_done          = r_done;
  assign busy              = r_busy;
  assign err               = r_err;
  assign lpddr2_address    = r_addr;
  assign lpddr2_write_data = r_wdata;
  assign lpddr2_rreq       = r_rreq;
  assign lpddr2_wreq       = r_wreq;

endmodule

// File: tb/tb_lpddr2_mem_bridge.sv
// tb_lpddr2_mem_bridge
// Directed bench for lpddr2_mem_bridge with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled 1ns after the
// rising edge. TIMEOUT_CYC is reduced to 16.
module tb_lpddr2_mem_bridge;

  logic        clk;
  logic        rst;
  logic [29:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_rreq;
  logic        cpu_wreq;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        busy;
  logic        err;
  logic [26:0] lpddr2_address;
  logic [31:0] lpddr2_write_data;
  logic [31:0] lpddr2_read_data;
  logic        lpddr2_rreq;
  logic        lpddr2_wreq;
  logic        lpddr2_waitrequest;
  logic        lpddr2_rdata_valid;

  int unsigned n_checks;
  int unsigned n_fail;
  logic        saw_done;

  lpddr2_mem_bridge #(
    .ADDR_W      (27),
    .TIMEOUT_CYC (16),
    .ERR_RDATA   (32'hDEAD_BEEF)
  ) u_dut (
    .clk                (clk),
    .rst                (rst),
    .cpu_addr           (cpu_addr),
    .cpu_wdata          (cpu_wdata),
    .cpu_rreq           (cpu_rreq),
    .cpu_wreq           (cpu_wreq),
    .cpu_rdata          (cpu_rdata),
    .cpu_done           (cpu_done),
    .busy               (busy),
    .err                (err),
    .lpddr2_address     (lpddr2_address),
    .lpddr2_write_data  (lpddr2_write_data),
    .lpddr2_read_data   (lpddr2_read_data),
    .lpddr2_rreq        (lpddr2_rreq),
    .lpddr2_wreq        (lpddr2_wreq),
    .lpddr2_waitrequest (lpddr2_waitrequest),
    .lpddr2_rdata_valid (lpddr2_rdata_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks           = 0;
    n_fail             = 0;
    rst                = 1'b1;
    cpu_addr           = '0;
    cpu_wdata          = '0;
    cpu_rreq           = 1'b0;
    cpu_wreq           = 1'b0;
    lpddr2_read_data   = '0;
    lpddr2_waitrequest = 1'b0;
    lpddr2_rdata_valid = 1'b0;

    // Reset state
    tick();
    chk("rst_done",  32'(cpu_done), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_rreq",  32'(lpddr2_rreq), 32'd0);
    chk("rst_wreq",  32'(lpddr2_wreq), 32'd0);
    chk("rst_addr",  32'(lpddr2_address), 32'd0);
    chk("rst_wdata", lpddr2_write_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Minimum-latency read: request at N
    @(negedge clk);
    cpu_addr = 30'h10;
    cpu_rreq = 1'b1;
    tick(); // N+1
    chk("rd_rreq_n1", 32'(lpddr2_rreq), 32'd1);
    chk("rd_wreq_n1", 32'(lpddr2_wreq), 32'd0);
    chk("rd_addr_n1", 32'(lpddr2_address), 32'h10);
    chk("rd_busy_n1", 32'(busy), 32'd1);
    @(negedge clk);
    cpu_rreq = 1'b0;
    tick(); // N+2
    chk("rd_rreq_n2", 32'(lpddr2_rreq), 32'd0);
    chk("rd_done_n2", 32'(cpu_done), 32'd0);
    @(negedge clk);
    lpddr2_rdata_valid = 1'b1;
    lpddr2_read_data   = 32'h1234_5678;
    tick(); // N+3
    chk("rd_done_n3",  32'(cpu_done), 32'd1);
    chk("rd_rdata_n3", cpu_rdata, 32'h1234_5678);
    chk("rd_rreq_n3",  32'(lpddr2_rreq), 32'd0);
    @(negedge clk);
    lpddr2_rdata_valid = 1'b0;
    lpddr2_read_data   = 32'h0;
    tick();
    chk("rd_done_n4",  32'(cpu_done), 32'd0);
    chk("rd_busy_n4",  32'(busy), 32'd0);
    chk("rd_rdata_n4", cpu_rdata, 32'h1234_5678);

    // Write with waitrequest high for 3 cycles
    @(negedge clk);
    cpu_addr           = 30'h20;
    cpu_wdata          = 32'hCAFE_0001;
    cpu_wreq           = 1'b1;
    lpddr2_waitrequest = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("wr_wreq",  32'(lpddr2_wreq), 32'd1);
      chk("wr_rreq",  32'(lpddr2_rreq), 32'd0);
      chk("wr_addr",  32'(lpddr2_address), 32'h20);
      chk("wr_wdata", lpddr2_write_data, 32'hCAFE_0001);
      chk("wr_done",  32'(cpu_done), 32'd0);
      @(negedge clk);
      cpu_wreq  = 1'b0;
      cpu_wdata = 32'h0;
      cpu_addr  = 30'h0;
      if (i == 3) lpddr2_waitrequest = 1'b0;
      tick();
    end
    chk("wr_done_pulse", 32'(cpu_done), 32'd1);
    chk("wr_wreq_off",   32'(lpddr2_wreq), 32'd0);
    tick();
    chk("wr_done_end", 32'(cpu_done), 32'd0);
    chk("wr_busy_end", 32'(busy), 32'd0);

    // Simultaneous read and write: write wins
    @(negedge clk);
    cpu_addr  = 30'h30;
    cpu_wdata = 32'h0000_0BEE;
    cpu_rreq  = 1'b1;
    cpu_wreq  = 1'b1;
    tick();
    chk("both_wreq", 32'(lpddr2_wreq), 32'd1);
    chk("both_rreq", 32'(lpddr2_rreq), 32'd0);
    chk("both_done_early", 32'(cpu_done), 32'd0);
    @(negedge clk);
    cpu_rreq = 1'b0;
    cpu_wreq = 1'b0;
    tick();
    chk("both_done",      32'(cpu_done), 32'd1);
    chk("both_rreq_done", 32'(lpddr2_rreq), 32'd0);
    tick();
    chk("both_done_once", 32'(cpu_done), 32'd0);
    chk("both_rreq_end",  32'(lpddr2_rreq), 32'd0);
    chk("both_busy_end",  32'(busy), 32'd0);

    // Out-of-range write address: error completion, no controller request
    chk("rng_err_before", 32'(err), 32'd0);
    @(negedge clk);
    cpu_addr  = 30'h0800_0000;
    cpu_wdata = 32'h1111_2222;
    cpu_wreq  = 1'b1;
    tick();
    chk("rng_done",  32'(cpu_done), 32'd1);
    chk("rng_err",   32'(err), 32'd1);
    chk("rng_wreq",  32'(lpddr2_wreq), 32'd0);
    chk("rng_rreq",  32'(lpddr2_rreq), 32'd0);
    chk("rng_rdata", cpu_rdata, 32'h1234_5678);
    @(negedge clk);
    cpu_wreq = 1'b0;
    cpu_addr = 30'h0;
    tick();
    chk("rng_done_end", 32'(cpu_done), 32'd0);
    chk("rng_busy_end", 32'(busy), 32'd0);
    chk("rng_err_sticky", 32'(err), 32'd1);

    // Reset asserted during RD_WAIT
    @(negedge clk);
    cpu_addr = 30'h50;
    cpu_rreq = 1'b1;
    tick();
    @(negedge clk);
    cpu_rreq = 1'b0;
    tick();
    chk("mid_busy_wait", 32'(busy), 32'd1);
    chk("mid_rreq_wait", 32'(lpddr2_rreq), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy",  32'(busy), 32'd0);
    chk("mid_rst_rreq",  32'(lpddr2_rreq), 32'd0);
    chk("mid_rst_err",   32'(err), 32'd0);
    chk("mid_rst_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    rst                = 1'b0;
    lpddr2_rdata_valid = 1'b1;
    lpddr2_read_data   = 32'h7777_7777;
    tick();
    chk("mid_late_done",  32'(cpu_done), 32'd0);
    chk("mid_late_rdata", cpu_rdata, 32'd0);
    chk("mid_late_busy",  32'(busy), 32'd0);
    @(negedge clk);
    lpddr2_rdata_valid = 1'b0;
    lpddr2_read_data   = 32'h0;

`ifdef LPDDR2_LAST_READ_CACHE_EN
    // Fill the cache from 0x10, then a repeat read hits without a request
    cpu_addr = 30'h10;
    cpu_rreq = 1'b1;
    tick();
    @(negedge clk);
    cpu_rreq           = 1'b0;
    lpddr2_rdata_valid = 1'b1;
    lpddr2_read_data   = 32'hA5A5_0010;
    tick();
    chk("cache_fill_done", 32'(cpu_done), 32'd1);
    @(negedge clk);
    lpddr2_rdata_valid = 1'b0;
    lpddr2_read_data   = 32'h0;
    tick();
    @(negedge clk);
    cpu_rreq = 1'b1;
    tick();
    chk("cache_hit_done",  32'(cpu_done), 32'd1);
    chk("cache_hit_rreq",  32'(lpddr2_rreq), 32'd0);
    chk("cache_hit_rdata", cpu_rdata, 32'hA5A5_0010);
    @(negedge clk);
    cpu_rreq = 1'b0;
    tick();
    chk("cache_hit_idle", 32'(busy), 32'd0);
    @(negedge clk);
`endif

    // Read timeout: rdata_valid never arrives
    cpu_addr = 30'h40;
    cpu_rreq = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (cpu_done || !busy) saw_done = 1'b1;
      @(negedge clk);
      cpu_rreq = 1'b0;
    end
    chk("to_no_early_done", 32'(saw_done), 32'd0);
    tick();
    chk("to_done",  32'(cpu_done), 32'd1);
    chk("to_err",   32'(err), 32'd1);
    chk("to_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("to_rreq",  32'(lpddr2_rreq), 32'd0);
    @(negedge clk);
    lpddr2_rdata_valid = 1'b1;
    lpddr2_read_data   = 32'h5555_5555;
    tick();
    chk("to_late_done",  32'(cpu_done), 32'd0);
    chk("to_late_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("to_late_busy",  32'(busy), 32'd0);
    chk("to_err_sticky", 32'(err), 32'd1);
    @(negedge clk);
    lpddr2_rdata_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
